// File: rtl/bcd_time_core.sv
// -----------------------------------------------------------------------------
// bcd_time_core
//   Time-of-day core. Prescales i_clk down to a 1 Hz tick and keeps HH:MM:SS
//   as BCD digits for an LCD string formatter. It supports run/pause, a
//   validated set-time handshake, minute/hour adjust pulses, a 12/24 h display
//   mode with a PM flag, and second/day-rollover strobes.
//
// Parameters
//   CLK_HZ      enabled i_clk cycles per second (>= 2)
//   RESET_HOUR  binary hour (0-23) loaded by reset
//   RESET_MIN   binary minute (0-59) loaded by reset; seconds reset to 0
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_run_en            1 = prescaler and time advance, 0 = hold
//   i_mode_12h          display hours in 12 h format (outputs only)
//   i_set_valid/o_set_ready, i_set_hour/min/sec   set-time handshake (binary)
//   o_set_err           1-cycle pulse: request rejected, field out of range
//   i_inc_min/i_inc_hour  1-cycle adjust pulses (no carry between fields)
//   o_sec1..o_hour_10   BCD digits (hours are display hours)
//   o_pm                internal hour >= 12
//   o_sec_pulse         1-cycle strobe per 1 Hz increment
//   o_day_pulse         1-cycle strobe on 23:59:59 -> 00:00:00
//
// FSM states
//   state  | meaning
//   S_RUN  | normal timekeeping, set-time requests accepted
//   S_LOAD | latched set-time being written into the digits
// -----------------------------------------------------------------------------
module bcd_time_core #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int RESET_HOUR = 0,
    parameter int RESET_MIN  = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_run_en,
    input  logic       i_mode_12h,
    input  logic       i_set_valid,
    output logic       o_set_ready,
    input  logic [4:0] i_set_hour,
    input  logic [5:0] i_set_min,
    input  logic [5:0] i_set_sec,
    output logic       o_set_err,
    input  logic       i_inc_min,
    input  logic       i_inc_hour,
    output logic [3:0] o_sec1,
    output logic [2:0] o_sec_10,
    output logic [3:0] o_min1,
    output logic [2:0] o_min_10,
    output logic [3:0] o_hour1,
    output logic [1:0] o_hour_10,
    output logic       o_pm,
    output logic       o_sec_pulse,
    output logic       o_day_pulse
);

    // Binary 0..59 -> {tens, units} by compare/subtract.
    function automatic logic [6:0] bin2bcd(input logic [5:0] v);
        if (v >= 6'd50)      return {3'd5, 4'(v - 6'd50)};
        else if (v >= 6'd40) return {3'd4, 4'(v - 6'd40)};
        else if (v >= 6'd30) return {3'd3, 4'(v - 6'd30)};
        else if (v >= 6'd20) return {3'd2, 4'(v - 6'd20)};
        else if (v >= 6'd10) return {3'd1, 4'(v - 6'd10)};
        else                 return {3'd0, v[3:0]};
    endfunction

    // Binary 0..29 -> {tens, units}; hours never exceed 23.
    function automatic logic [5:0] hour2bcd(input logic [4:0] v);
        if (v >= 5'd20)      return {2'd2, 4'(v - 5'd20)};
        else if (v >= 5'd10) return {2'd1, 4'(v - 5'd10)};
        else                 return {2'd0, v[3:0]};
    endfunction

    localparam int              PW        = $clog2(CLK_HZ);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [5:0]      RST_HOUR  = hour2bcd(5'(RESET_HOUR));
    localparam logic [6:0]      RST_MIN   = bin2bcd(6'(RESET_MIN));

    typedef enum logic {S_RUN = 1'b0, S_LOAD = 1'b1} state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic          r_set_ready;
    logic          r_set_err;
    logic          r_sec_pulse;
    logic          r_day_pulse;
    logic [3:0]    r_sec1;
    logic [2:0]    r_sec_10;
    logic [3:0]    r_min1;
    logic [2:0]    r_min_10;
    logic [3:0]    r_hour1;
    logic [1:0]    r_hour_10;
    logic [4:0]    r_ld_hour;
    logic [5:0]    r_ld_min;
    logic [5:0]    r_ld_sec;

    logic          w_tick;
    logic          w_in_range;
    logic          w_sec_wrap;
    logic          w_min_wrap;
    logic          w_hour_wrap;
    logic [5:0]    w_ld_hour_bcd;
    logic [6:0]    w_ld_min_bcd;
    logic [6:0]    w_ld_sec_bcd;
    logic [4:0]    w_hour_bin;
    logic [4:0]    w_disp_bin;
    logic [5:0]    w_disp_bcd;

    assign w_tick        = (r_presc == PRESC_MAX) && i_run_en;
    assign w_in_range    = (i_set_hour <= 5'd23) && (i_set_min <= 6'd59) &&
                           (i_set_sec <= 6'd59);
    assign w_sec_wrap    = (r_sec1 == 4'd9) && (r_sec_10 == 3'd5);
    assign w_min_wrap    = (r_min1 == 4'd9) && (r_min_10 == 3'd5);
    assign w_hour_wrap   = (r_hour_10 == 2'd2) && (r_hour1 == 4'd3);
    assign w_ld_hour_bcd = hour2bcd(r_ld_hour);
    assign w_ld_min_bcd  = bin2bcd(r_ld_min);
    assign w_ld_sec_bcd  = bin2bcd(r_ld_sec);

    // Display hours: 12 h maps 0 -> 12 and 13..23 -> 1..11.
    assign w_hour_bin = 5'(r_hour_10) * 5'd10 + 5'(r_hour1);

    always_comb begin
        w_disp_bin = w_hour_bin;
        if (i_mode_12h) begin
            if (w_hour_bin == 5'd0)
                w_disp_bin = 5'd12;
            else if (w_hour_bin > 5'd12)
                w_disp_bin = w_hour_bin - 5'd12;
        end
    end

    assign w_disp_bcd = hour2bcd(w_disp_bin);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_RUN;
            r_presc     <= '0;
            r_set_ready <= 1'b1;
            r_set_err   <= 1'b0;
            r_sec_pulse <= 1'b0;
            r_day_pulse <= 1'b0;
            r_sec1      <= 4'd0;
            r_sec_10    <= 3'd0;
            r_min1      <= RST_MIN[3:0];
            r_min_10    <= RST_MIN[6:4];
            r_hour1     <= RST_HOUR[3:0];
            r_hour_10   <= RST_HOUR[5:4];
            r_ld_hour   <= 5'd0;
            r_ld_min    <= 6'd0;
            r_ld_sec    <= 6'd0;
        end else begin
            r_set_err   <= 1'b0;
            r_sec_pulse <= 1'b0;
            r_day_pulse <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    // Load wins over adjust and tick; the second restarts here.
                    r_sec1      <= w_ld_sec_bcd[3:0];
                    r_sec_10    <= w_ld_sec_bcd[6:4];
                    r_min1      <= w_ld_min_bcd[3:0];
                    r_min_10    <= w_ld_min_bcd[6:4];
                    r_hour1     <= w_ld_hour_bcd[3:0];
                    r_hour_10   <= w_ld_hour_bcd[5:4];
                    r_presc     <= '0;
                    r_state     <= S_RUN;
                    r_set_ready <= 1'b1;
                end
                S_RUN: begin
                    if (i_run_en)
                        r_presc <= w_tick ? '0 : r_presc + PW'(1);

                    if (i_inc_min || i_inc_hour) begin
                        // Adjust drops a coincident tick; no carries between fields.
                        if (i_inc_min) begin
                            if (w_min_wrap) begin
                                r_min1   <= 4'd0;
                                r_min_10 <= 3'd0;
                            end else if (r_min1 == 4'd9) begin
                                r_min1   <= 4'd0;
                                r_min_10 <= r_min_10 + 3'd1;
                            end else begin
                                r_min1   <= r_min1 + 4'd1;
                            end
                        end
                        if (i_inc_hour) begin
                            if (w_hour_wrap) begin
                                r_hour1   <= 4'd0;
                                r_hour_10 <= 2'd0;
                            end else if (r_hour1 == 4'd9) begin
                                r_hour1   <= 4'd0;
                                r_hour_10 <= r_hour_10 + 2'd1;
                            end else begin
                                r_hour1   <= r_hour1 + 4'd1;
                            end
                        end
                    end else if (w_tick) begin
                        r_sec_pulse <= 1'b1;
                        r_day_pulse <= w_sec_wrap && w_min_wrap && w_hour_wrap;
                        if (r_sec1 == 4'd9) begin
                            r_sec1   <= 4'd0;
                            r_sec_10 <= (r_sec_10 == 3'd5) ? 3'd0 : r_sec_10 + 3'd1;
                        end else begin
                            r_sec1   <= r_sec1 + 4'd1;
                        end
                        if (w_sec_wrap) begin
                            if (r_min1 == 4'd9) begin
                                r_min1   <= 4'd0;
                                r_min_10 <= (r_min_10 == 3'd5) ? 3'd0 : r_min_10 + 3'd1;
                            end else begin
                                r_min1   <= r_min1 + 4'd1;
                            end
                            if (w_min_wrap) begin
                                if (w_hour_wrap) begin
                                    r_hour1   <= 4'd0;
                                    r_hour_10 <= 2'd0;
                                end else if (r_hour1 == 4'd9) begin
                                    r_hour1   <= 4'd0;
                                    r_hour_10 <= r_hour_10 + 2'd1;
                                end else begin
                                    r_hour1   <= r_hour1 + 4'd1;
                                end
                            end
                        end
                    end

                    // Ready is always high in S_RUN, so valid alone is a handshake.
                    if (i_set_valid) begin
                        if (w_in_range) begin
                            r_ld_hour   <= i_set_hour;
                            r_ld_min    <= i_set_min;
                            r_ld_sec    <= i_set_sec;
                            r_state     <= S_LOAD;
                            r_set_ready <= 1'b0;
                        end else begin
                            r_set_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= S_RUN;
                    r_set_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_set_ready = r_set_ready;
    assign o_set_err   = r_set_err;
    assign o_sec_pulse = r_sec_pulse;
    assign o_day_pulse = r_day_pulse;
    assign o_sec1      = r_sec1;
    assign o_sec_10    = r_sec_10;
    assign o_min1      = r_min1;
    assign o_min_10    = r_min_10;
    assign o_hour1     = w_disp_bcd[3:0];
    assign o_hour_10   = w_disp_bcd[5:4];
    assign o_pm        = (w_hour_bin >= 5'd12);

endmodule

// File: tb/tb_bcd_time_core.sv
module tb_bcd_time_core;

    localparam int CLK_HZ = 4;
    localparam int RH     = 23;
    localparam int RM     = 59;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run_en = 1'b0;
    logic       mode_12h = 1'b0;
    logic       set_valid = 1'b0;
    logic [4:0] set_hour = '0;
    logic [5:0] set_min = '0;
    logic [5:0] set_sec = '0;
    logic       inc_min = 1'b0;
    logic       inc_hour = 1'b0;
    logic       set_ready, set_err, pm, sec_pulse, day_pulse;
    logic [3:0] sec1, min1, hour1;
    logic [2:0] sec_10, min_10;
    logic [1:0] hour_10;

    int total = 0;
    int bad   = 0;

    // Reference model: time as seconds-of-day plus prescaler phase.
    int m_t, m_presc, m_pend, m_ld, m_ready, m_err, m_secp, m_dayp;
    int day_seen = 0;

    always #5 clk = ~clk;

    bcd_time_core #(.CLK_HZ(CLK_HZ), .RESET_HOUR(RH), .RESET_MIN(RM)) dut (
        .i_clk(clk), .i_rst(rst), .i_run_en(run_en), .i_mode_12h(mode_12h),
        .i_set_valid(set_valid), .o_set_ready(set_ready),
        .i_set_hour(set_hour), .i_set_min(set_min), .i_set_sec(set_sec),
        .o_set_err(set_err), .i_inc_min(inc_min), .i_inc_hour(inc_hour),
        .o_sec1(sec1), .o_sec_10(sec_10), .o_min1(min1), .o_min_10(min_10),
        .o_hour1(hour1), .o_hour_10(hour_10), .o_pm(pm),
        .o_sec_pulse(sec_pulse), .o_day_pulse(day_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int  h, mi, s;
        bit  tick;
        m_err  = 0;
        m_secp = 0;
        m_dayp = 0;
        if (rst) begin
            m_t = RH * 3600 + RM * 60;
            m_presc = 0; m_pend = 0; m_ready = 1;
        end else if (m_pend != 0) begin
            m_t = m_ld;
            m_presc = 0; m_pend = 0; m_ready = 1;
        end else begin
            tick = (m_presc == CLK_HZ - 1) && run_en;
            if (run_en) m_presc = (m_presc + 1) % CLK_HZ;
            h  = m_t / 3600;
            mi = (m_t / 60) % 60;
            s  = m_t % 60;
            if (inc_min || inc_hour) begin
                if (inc_min)  mi = (mi + 1) % 60;
                if (inc_hour) h  = (h + 1) % 24;
                m_t = h * 3600 + mi * 60 + s;
            end else if (tick) begin
                m_secp = 1;
                m_dayp = (m_t == 86399) ? 1 : 0;
                m_t = (m_t + 1) % 86400;
            end
            if (set_valid) begin
                if (int'(set_hour) <= 23 && int'(set_min) <= 59 && int'(set_sec) <= 59) begin
                    m_pend = 1; m_ready = 0;
                    m_ld = int'(set_hour) * 3600 + int'(set_min) * 60 + int'(set_sec);
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        int h, mi, s, dh;
        h  = m_t / 3600;
        mi = (m_t / 60) % 60;
        s  = m_t % 60;
        dh = h;
        if (mode_12h) dh = (h == 0) ? 12 : (h > 12) ? h - 12 : h;
        check("sec1",    32'(sec1),     32'(s % 10));
        check("sec_10",  32'(sec_10),   32'(s / 10));
        check("min1",    32'(min1),     32'(mi % 10));
        check("min_10",  32'(min_10),   32'(mi / 10));
        check("hour1",   32'(hour1),    32'(dh % 10));
        check("hour_10", 32'(hour_10),  32'(dh / 10));
        check("pm",      32'(pm),       32'((h >= 12) ? 1 : 0));
        check("ready",   32'(set_ready), 32'(m_ready));
        check("set_err", 32'(set_err),   32'(m_err));
        check("sec_pulse", 32'(sec_pulse), 32'(m_secp));
        check("day_pulse", 32'(day_pulse), 32'(m_dayp));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        if (day_pulse) day_seen++;
    endtask

    task automatic do_set(input int h, input int m, input int s);
        set_hour  = 5'(h);
        set_min   = 6'(m);
        set_sec   = 6'(s);
        set_valid = 1'b1;
        step();
        set_valid = 1'b0;
    endtask

    function automatic logic [19:0] digits();
        return {hour_10, hour1, min_10, min1, sec_10, sec1};
    endfunction

    initial begin
        // Reset state
        rst = 1'b1; run_en = 1'b1;
        step(); step();
        rst = 1'b0;
        check("reset_time", 32'(digits()), 32'({2'd2, 4'd3, 3'd5, 4'd9, 3'd0, 4'd0}));
        check("reset_ready", 32'(set_ready), 32'd1);

        // Free run through the day rollover
        repeat (242) step();
        check("day_seen", 32'(day_seen), 32'd1);
        check("midnight", 32'(digits()), 32'd0);

        // Set 13:07:45, then 12 h display
        do_set(13, 7, 45);
        check("ready_low", 32'(set_ready), 32'd0);
        step();
        check("set_digits", 32'(digits()), 32'({2'd1, 4'd3, 3'd0, 4'd7, 3'd4, 4'd5}));
        check("ready_back", 32'(set_ready), 32'd1);
        mode_12h = 1'b1;
        #1;
        check("h12_13", 32'({hour_10, hour1, pm}), 32'({2'd0, 4'd1, 1'b1}));
        do_set(0, 0, 0);
        step();
        check("h12_00", 32'({hour_10, hour1, pm}), 32'({2'd1, 4'd2, 1'b0}));
        mode_12h = 1'b0;

        // Out-of-range requests rejected
        do_set(5, 60, 0);
        check("err_min", 32'({set_err, set_ready}), 32'({1'b1, 1'b1}));
        step();
        do_set(24, 0, 0);
        check("err_hour", 32'({set_err, set_ready}), 32'({1'b1, 1'b1}));
        step();

        // Pause mid-count then resume
        step(); step();
        run_en = 1'b0;
        repeat (10) step();
        run_en = 1'b1;
        repeat (8) step();

        // inc_min on the tick cycle at 12:59:30
        do_set(12, 59, 30);
        step();
        repeat (3) step();
        inc_min = 1'b1;
        step();
        inc_min = 1'b0;
        check("inc_min", 32'(digits()), 32'({2'd1, 4'd2, 3'd0, 4'd0, 3'd3, 4'd0}));
        check("inc_min_nosec", 32'(sec_pulse), 32'd0);

        // inc_hour at 23 wraps without day strobe
        do_set(23, 0, 0);
        step();
        inc_hour = 1'b1;
        step();
        inc_hour = 1'b0;
        check("inc_hour", 32'({hour_10, hour1}), 32'd0);
        check("inc_hour_noday", 32'(day_pulse), 32'd0);

        // Reset during S_LOAD discards the load
        do_set(1, 2, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_load", 32'(digits()), 32'({2'd2, 4'd3, 3'd5, 4'd9, 3'd0, 4'd0}));
        check("rst_load_ready", 32'(set_ready), 32'd1);
        step();
        check("rst_load_kept", 32'({hour_10, hour1, min_10, min1}), 32'({2'd2, 4'd3, 3'd5, 4'd9}));

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            rst       = ($urandom_range(0, 499) == 0);
            run_en    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) mode_12h = ~mode_12h;
            inc_min   = ($urandom_range(0, 29) == 0);
            inc_hour  = ($urandom_range(0, 29) == 0);
            set_valid = ($urandom_range(0, 39) == 0);
            set_hour  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 23));
            set_min   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 59));
            set_sec   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 59));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
